// File: rtl/hbs_scheduler.sv
// Round-robin front end that shares one high-bit-search unit among NUM_REQ
// requesters, with one transaction in flight and a bounded wait for the unit's answer.
module hbs_scheduler #(
    parameter int INPUT_WIDTH = 32,
    parameter int IDX_WIDTH   = 5,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [INPUT_WIDTH-1:0]         hbs_data,
    output logic                           hbs_start,
    input  logic                           hbs_done,
    input  logic [IDX_WIDTH-1:0]           hbs_idx,
    input  logic                           hbs_found,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [IDX_WIDTH-1:0]           rsp_idx,
    output logic                           rsp_found,
    output logic                           rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                 state, state_next;
    logic [ID_WIDTH-1:0]    ptr;
    logic [ID_WIDTH-1:0]    id_q;
    logic [INPUT_WIDTH-1:0] data_q;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic                   found_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt;
    logic                   timeout_hit;

    logic                   hi_any, lo_any, grant_any;
    logic [ID_WIDTH-1:0]    hi_id, lo_id, grant_id;
    logic [INPUT_WIDTH-1:0] hi_data, lo_data, grant_data;

    // Two-pass priority search: lowest valid index at or above ptr wins,
    // otherwise wrap around to the lowest valid index overall.
    always_comb begin
        hi_any  = 1'b0;
        lo_any  = 1'b0;
        hi_id   = '0;
        lo_id   = '0;
        hi_data = '0;
        lo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !lo_any) begin
                lo_any  = 1'b1;
                lo_id   = ID_WIDTH'(i);
                lo_data = req_data[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
            if (req_valid[i] && (ID_WIDTH'(i) >= ptr) && !hi_any) begin
                hi_any  = 1'b1;
                hi_id   = ID_WIDTH'(i);
                hi_data = req_data[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
        grant_any  = lo_any;
        grant_id   = hi_any ? hi_id   : lo_id;
        grant_data = hi_any ? hi_data : lo_data;
    end

    // Gated by rst_n so no handshake can appear to complete while reset is held.
    assign req_ready = (rst_n && (state == IDLE) && grant_any)
                       ? (NUM_REQ'(1) << grant_id) : '0;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = (grant_data != '0) ? ISSUE : RESP;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (hbs_done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A zero word skips the unit, so its response fields are preloaded at accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= '0;
            id_q    <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        data_q  <= grant_data;
                        id_q    <= grant_id;
                        idx_q   <= '0;
                        found_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (hbs_done) begin
                        idx_q   <= hbs_idx;
                        found_q <= hbs_found;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        idx_q   <= '0;
                        found_q <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr <= (id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id_q + ID_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign hbs_start = (state == ISSUE);
    assign hbs_data  = data_q;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_idx   = idx_q;
    assign rsp_found = found_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_hbs_scheduler.sv
// Bench for hbs_scheduler: directed scenarios plus randomized transactions
// checked against a round-robin / highest-bit reference model and a stub search unit.
module tb_hbs_scheduler;

    localparam int W   = 32;
    localparam int IW  = 5;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     hbs_data;
    logic             hbs_start;
    logic             hbs_done;
    logic [IW-1:0]    hbs_idx;
    logic             hbs_found;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [IW-1:0]    rsp_idx;
    logic             rsp_found;
    logic             rsp_err;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;
    int stub_delay = 1;
    int force_req  = 0;
    int force_seen = 0;
    int pend       = 0;
    logic [W-1:0] stub_word = '0;

    hbs_scheduler #(
        .INPUT_WIDTH(W), .IDX_WIDTH(IW), .NUM_REQ(N), .ID_WIDTH(IDW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .hbs_data(hbs_data), .hbs_start(hbs_start),
        .hbs_done(hbs_done), .hbs_idx(hbs_idx), .hbs_found(hbs_found),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_idx(rsp_idx), .rsp_found(rsp_found), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic int highest_bit(input logic [W-1:0] w);
        int r = 0;
        logic [W-1:0] t;
        for (int b = 0; b < W; b++) begin
            t = w >> b;
            if (t[0]) r = b;
        end
        return r;
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s = v >> ((p + k) % N);
            if (s[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Stub search unit: answers stub_delay cycles after start (0 = never);
    // force_req bumps inject one stray done strobe on the following cycle.
    initial begin
        hbs_done  = 1'b0;
        hbs_idx   = '0;
        hbs_found = 1'b0;
        forever begin
            @(negedge clk);
            if (hbs_start === 1'b1) begin
                pend      = stub_delay;
                stub_word = hbs_data;
            end
            @(posedge clk);
            #1;
            hbs_done = 1'b0;
            if (force_req != force_seen) begin
                force_seen = force_req;
                hbs_done   = 1'b1;
                hbs_idx    = 5'd7;
                hbs_found  = 1'b1;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    hbs_done  = 1'b1;
                    hbs_idx   = IW'(highest_bit(stub_word));
                    hbs_found = (stub_word != '0);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        mptr  = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        next_cycle();
        next_cycle();
        mid();
        total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
        total++; if (hbs_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_hbs_start: got %b expected 0", hbs_start); end
        total++; if (hbs_data !== '0) begin bad++; $display("[TB] FAIL reset_hbs_data: got %h expected 0", hbs_data); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        total++; if (rsp_id !== '0) begin bad++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        total++; if (rsp_idx !== '0) begin bad++; $display("[TB] FAIL reset_rsp_idx: got %0d expected 0", rsp_idx); end
        total++; if (rsp_found !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_found: got %b expected 0", rsp_found); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        req_valid = '0;
        next_cycle();
        rst_n = 1'b1;
        mptr  = 0;
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready  = 1'b1;
        stub_delay = 1;
        req_data[0 +: W] = 32'hDEADBEEF;
        req_valid = 4'b0001;
        mid();
        total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL single_grant: got %b expected 0001", req_ready); end
        next_cycle();
        req_valid = '0;
        mid();
        total++; if (hbs_start !== 1'b1) begin bad++; $display("[TB] FAIL single_start_t1: got %b expected 1", hbs_start); end
        total++; if (hbs_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_hbs_data: got %h expected deadbeef", hbs_data); end
        next_cycle();
        mid();
        total++; if ({hbs_start, rsp_valid} !== 2'b00) begin bad++; $display("[TB] FAIL single_t2: got start/valid %b expected 00", {hbs_start, rsp_valid}); end
        next_cycle();
        mid();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_rsp_t3: got %b expected 1", rsp_valid); end
        total++; if ({rsp_id, rsp_idx, rsp_found, rsp_err} !== {2'd0, 5'd31, 1'b1, 1'b0})
            begin bad++; $display("[TB] FAIL single_rsp_fields: got id=%0d idx=%0d found=%b err=%b expected 0/31/1/0", rsp_id, rsp_idx, rsp_found, rsp_err); end
        mptr = 1;
        next_cycle();
        mid();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] words [4] = '{32'h00005403, 32'h00000024, 32'h005030BE, 32'h30400F15};
        int n;
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
        req_valid  = 4'b1111;
        rsp_ready  = 1'b1;
        stub_delay = 1;
        for (int t = 0; t < 5; t++) begin
            mid();
            n = 0;
            while (req_ready === '0 && n < 10) begin next_cycle(); mid(); n++; end
            total++; if (req_ready !== (N'(1) << order[t])) begin bad++; $display("[TB] FAIL rr_grant%0d: got %b expected requester %0d", t, req_ready, order[t]); end
            next_cycle();
            mid();
            n = 0;
            while (rsp_valid !== 1'b1 && n < 40) begin next_cycle(); mid(); n++; end
            total++; if ({rsp_valid, rsp_id, rsp_idx} !== {1'b1, IDW'(order[t]), IW'(highest_bit(words[order[t]]))})
                begin bad++; $display("[TB] FAIL rr_rsp%0d: got valid=%b id=%0d idx=%0d expected 1/%0d/%0d", t, rsp_valid, rsp_id, rsp_idx, order[t], highest_bit(words[order[t]])); end
            mptr = (order[t] + 1) % N;
            next_cycle();
        end
        req_valid = '0;
    endtask

    task automatic test_zero();
        rsp_ready = 1'b1;
        req_data[2*W +: W] = '0;
        req_valid = 4'b0100;
        mid();
        total++; if (req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL zero_grant: got %b expected 0100", req_ready); end
        next_cycle();
        req_valid = '0;
        mid();
        total++; if (hbs_start !== 1'b0) begin bad++; $display("[TB] FAIL zero_no_start: got %b expected 0", hbs_start); end
        total++; if ({rsp_valid, rsp_id, rsp_found, rsp_idx, rsp_err} !== {1'b1, 2'd2, 1'b0, 5'd0, 1'b0})
            begin bad++; $display("[TB] FAIL zero_rsp: got valid=%b id=%0d found=%b idx=%0d err=%b expected 1/2/0/0/0", rsp_valid, rsp_id, rsp_found, rsp_idx, rsp_err); end
        mptr = 3;
        next_cycle();
    endtask

    task automatic test_timeout();
        int c;
        rsp_ready  = 1'b0;
        stub_delay = 0;
        req_data[1*W +: W] = 32'h00000080;
        req_valid = 4'b0010;
        mid();
        total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL to_grant: got %b expected 0010", req_ready); end
        next_cycle();
        req_valid = '0;
        c = 1;
        mid();
        total++; if (hbs_start !== 1'b1) begin bad++; $display("[TB] FAIL to_start: got %b expected 1", hbs_start); end
        while (rsp_valid !== 1'b1 && c < 40) begin next_cycle(); c++; mid(); end
        total++; if (c != 2 + TO) begin bad++; $display("[TB] FAIL to_latency: got %0d expected %0d", c, 2 + TO); end
        total++; if ({rsp_id, rsp_err, rsp_found, rsp_idx} !== {2'd1, 1'b1, 1'b0, 5'd0})
            begin bad++; $display("[TB] FAIL to_rsp: got id=%0d err=%b found=%b idx=%0d expected 1/1/0/0", rsp_id, rsp_err, rsp_found, rsp_idx); end
        force_req++;
        next_cycle();
        mid();
        total++; if ({rsp_valid, rsp_err, rsp_found, rsp_idx} !== {1'b1, 1'b1, 1'b0, 5'd0})
            begin bad++; $display("[TB] FAIL to_late_done: got valid=%b err=%b found=%b idx=%0d expected 1/1/0/0", rsp_valid, rsp_err, rsp_found, rsp_idx); end
        rsp_ready = 1'b1;
        next_cycle();
        mid();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL to_rsp_drop: got %b expected 0", rsp_valid); end
        mptr = 2;
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] v = 4'b1001;
        logic [W-1:0] w0, w3, wg;
        int g, g2, n;
        w0 = $urandom | 32'h1;
        w3 = $urandom | 32'h1;
        req_data[0 +: W]   = w0;
        req_data[3*W +: W] = w3;
        rsp_ready  = 1'b0;
        stub_delay = 2;
        req_valid  = v;
        g  = model_grant(v, mptr);
        wg = (g == 0) ? w0 : w3;
        mid();
        total++; if (req_ready !== (N'(1) << g)) begin bad++; $display("[TB] FAIL bp_grant: got %b expected requester %0d", req_ready, g); end
        next_cycle();
        mid();
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin next_cycle(); mid(); n++; end
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            mid();
            total++; if ({rsp_valid, rsp_id, rsp_idx, rsp_found, rsp_err, req_ready} !== {1'b1, IDW'(g), IW'(highest_bit(wg)), 1'b1, 1'b0, 4'b0000})
                begin bad++; $display("[TB] FAIL bp_hold%0d: got valid=%b id=%0d idx=%0d found=%b err=%b ready=%b expected 1/%0d/%0d/1/0/0000", k, rsp_valid, rsp_id, rsp_idx, rsp_found, rsp_err, req_ready, g, highest_bit(wg)); end
        end
        next_cycle();
        rsp_ready = 1'b1;
        mid();
        total++; if ({rsp_valid, req_ready} !== {1'b1, 4'b0000}) begin bad++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 1/0000", rsp_valid, req_ready); end
        mptr = (g + 1) % N;
        g2 = model_grant(v, mptr);
        next_cycle();
        mid();
        total++; if (req_ready !== (N'(1) << g2)) begin bad++; $display("[TB] FAIL bp_next_grant: got %b expected requester %0d", req_ready, g2); end
        next_cycle();
        req_valid = '0;
        mid();
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin next_cycle(); mid(); n++; end
        total++; if ({rsp_valid, rsp_id} !== {1'b1, IDW'(g2)}) begin bad++; $display("[TB] FAIL bp_second_rsp: got valid=%b id=%0d expected 1/%0d", rsp_valid, rsp_id, g2); end
        mptr = (g2 + 1) % N;
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        logic [N-1:0] v = 4'b0101;
        logic [W-1:0] w0;
        int g, n;
        w0 = $urandom | 32'h1;
        req_data[0 +: W]   = w0;
        req_data[2*W +: W] = $urandom | 32'h1;
        rsp_ready  = 1'b1;
        stub_delay = 0;
        req_valid  = v;
        g = model_grant(v, mptr);
        mid();
        total++; if (req_ready !== (N'(1) << g)) begin bad++; $display("[TB] FAIL rw_grant: got %b expected requester %0d", req_ready, g); end
        next_cycle();
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        force_req++;
        mid();
        total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL rw_ready_in_reset: got %b expected 0", req_ready); end
        next_cycle();
        rst_n = 1'b1;
        mptr  = 0;
        mid();
        total++; if ({hbs_start, hbs_data, rsp_valid, rsp_id, rsp_idx, rsp_found, rsp_err} !== '0)
            begin bad++; $display("[TB] FAIL rw_reset_outputs: got start=%b data=%h valid=%b id=%0d idx=%0d found=%b err=%b expected all 0", hbs_start, hbs_data, rsp_valid, rsp_id, rsp_idx, rsp_found, rsp_err); end
        total++; if (req_ready !== (N'(1) << model_grant(v, 0))) begin bad++; $display("[TB] FAIL rw_regrant: got %b expected requester %0d", req_ready, model_grant(v, 0)); end
        stub_delay = 1;
        next_cycle();
        req_valid = '0;
        mid();
        total++; if ({hbs_start, hbs_data, rsp_valid} !== {1'b1, w0, 1'b0})
            begin bad++; $display("[TB] FAIL rw_new_issue: got start=%b data=%h valid=%b expected 1/%h/0", hbs_start, hbs_data, rsp_valid, w0); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin next_cycle(); mid(); n++; end
        total++; if ({rsp_valid, rsp_id, rsp_idx} !== {1'b1, 2'd0, IW'(highest_bit(w0))})
            begin bad++; $display("[TB] FAIL rw_rsp: got valid=%b id=%0d idx=%0d expected 1/0/%0d", rsp_valid, rsp_id, rsp_idx, highest_bit(w0)); end
        mptr = 1;
        next_cycle();
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [W-1:0] words [N];
        logic [W-1:0] w;
        int g, d, lat, exp_lat, exp_idx, hold;
        logic exp_found, exp_err;
        for (int it = 0; it < 40; it++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                words[i] = ($urandom_range(0, 5) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            end
            g = model_grant(v, mptr);
            if (it < 2 && words[g] == '0) words[g] = 32'h1;
            for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
            w = words[g];
            if (it == 0)      d = TO;
            else if (it == 1) d = 0;
            else              d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
            stub_delay = d;
            exp_lat   = (w == '0) ? 1 : ((d == 0) ? 2 + TO : d + 2);
            exp_found = (w != '0) && (d != 0);
            exp_err   = (w != '0) && (d == 0);
            exp_idx   = exp_found ? highest_bit(w) : 0;
            rsp_ready = 1'b0;
            req_valid = v;
            mid();
            total++; if (req_ready !== (N'(1) << g)) begin bad++; $display("[TB] FAIL rand%0d_grant: got %b expected requester %0d", it, req_ready, g); end
            next_cycle();
            req_valid = '0;
            lat = 1;
            mid();
            while (rsp_valid !== 1'b1 && lat < 40) begin next_cycle(); lat++; mid(); end
            total++; if (lat != exp_lat) begin bad++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", it, lat, exp_lat); end
            total++; if ({rsp_id, rsp_idx, rsp_found, rsp_err} !== {IDW'(g), IW'(exp_idx), exp_found, exp_err})
                begin bad++; $display("[TB] FAIL rand%0d_rsp: got id=%0d idx=%0d found=%b err=%b expected %0d/%0d/%b/%b", it, rsp_id, rsp_idx, rsp_found, rsp_err, g, exp_idx, exp_found, exp_err); end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin next_cycle(); mid(); end
            rsp_ready = 1'b1;
            next_cycle();
            rsp_ready = 1'b0;
            mptr = (g + 1) % N;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
